// File: rtl/scoreboard_register_file_pkg.sv
// Shared defaults for the scoreboarded register file and its per-register
// pending-writer counters.
package regfile_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned NREG_DEF    = 32;
  localparam int unsigned PW_DEF      = 2;
  localparam int unsigned SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h2ffc;
  localparam int unsigned X17_IDX     = 17;

endpackage

// File: rtl/scoreboard_register_file_pend_counter.sv
// Saturating pending-writer counter for one architectural register.
// A simultaneous inc and dec cancel; dec at zero is ignored.
module pend_counter #(
  parameter int unsigned PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [PW-1:0] cnt_o,
  output logic          sat_o
);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == '1);

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending-writer scoreboard, writeback
// bypass on reads, issue back-pressure on saturated counters and flush.
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned      XLEN    = XLEN_DEF,
  parameter int unsigned      NREG    = NREG_DEF,
  parameter int unsigned      PW      = PW_DEF,
  parameter int unsigned      SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(SP_INIT_DEF)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NREG)-1:0]       rs1,
  input  logic [$clog2(NREG)-1:0]       rs2,
  output logic [XLEN-1:0]               rs1_dout,
  output logic [XLEN-1:0]               rs2_dout,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  input  logic                          iss_en,
  input  logic [$clog2(NREG)-1:0]       iss_rd,
  output logic                          iss_ready,
  input  logic                          wr_en,
  input  logic [$clog2(NREG)-1:0]       wr_rd,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          flush,
  output logic [$clog2(NREG)+PW-1:0]    pend_total,
  output logic [XLEN-1:0]               x17
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned TW = AW + PW;

  logic [XLEN-1:0]            regs_q [NREG];
  logic [XLEN-1:0]            regs_d [NREG];
  logic [NREG-1:0][PW-1:0]    pend;
  logic [NREG-1:0]            sat;
  logic [NREG-1:1]            inc;
  logic [NREG-1:1]            wr_hit;
  logic                       iss_acc;
  logic                       hit1;
  logic                       hit2;

  // Saturated destination is still accepted when its writeback lands the
  // same cycle, since inc and dec cancel and the count stays at PMAX.
  assign iss_ready = flush || (iss_rd == '0) || !sat[iss_rd] ||
                     (wr_en && (wr_rd == iss_rd));
  assign iss_acc   = iss_en && iss_ready && !flush;

  always_comb begin
    inc    = '0;
    wr_hit = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc[r]    = iss_acc && (iss_rd == AW'(r));
      wr_hit[r] = wr_en && (wr_rd == AW'(r));
    end
  end

  assign pend[0] = '0;
  assign sat[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    pend_counter #(.PW(PW)) u_pend (
      .clk   (clk),
      .rst_n (reset),
      .inc_i (inc[r]),
      .dec_i (wr_hit[r]),
      .clr_i (flush),
      .cnt_o (pend[r]),
      .sat_o (sat[r])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      if (wr_hit[r]) begin
        regs_d[r] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  assign hit1 = wr_en && (wr_rd == rs1);
  assign hit2 = wr_en && (wr_rd == rs2);

  always_comb begin
    rs1_dout = '0;
    rs2_dout = '0;
    if (rs1 != '0) rs1_dout = hit1 ? wr_data : regs_q[rs1];
    if (rs2 != '0) rs2_dout = hit2 ? wr_data : regs_q[rs2];
  end

  // Busy means a writer remains after this cycle's writeback retires one.
  assign rs1_busy = (rs1 != '0) && (pend[rs1] > PW'(hit1));
  assign rs2_busy = (rs2 != '0) && (pend[rs2] > PW'(hit2));

  always_comb begin
    pend_total = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      pend_total = pend_total + TW'(pend[r]);
    end
  end

  if (NREG > X17_IDX) begin : g_x17
    assign x17 = regs_q[X17_IDX];
  end else begin : g_no_x17
    assign x17 = '0;
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file; expectations are queued by the
// stimulus and checked by an independent monitor process.
module tb_scoreboard_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, iss_rd, wr_rd;
  logic [31:0] rs1_dout, rs2_dout, wr_data, x17;
  logic        rs1_busy, rs2_busy, iss_en, iss_ready, wr_en, flush;
  logic [6:0]  pend_total;

  scoreboard_register_file #(
    .XLEN    (32),
    .NREG    (32),
    .PW      (2),
    .SP_IDX  (2),
    .SP_INIT (32'h2ffc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_dout   (rs1_dout),
    .rs2_dout   (rs2_dout),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .iss_en     (iss_en),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .flush      (flush),
    .pend_total (pend_total),
    .x17        (x17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_RS1D, S_RS2D, S_RS1B, S_RS2B, S_RDY, S_TOT, S_X17} sel_e;
  typedef struct {
    string       nm;
    sel_e        sel;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  event  chk_ev;
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_RS1D:  return rs1_dout;
      S_RS2D:  return rs2_dout;
      S_RS1B:  return {31'd0, rs1_busy};
      S_RS2B:  return {31'd0, rs2_busy};
      S_RDY:   return {31'd0, iss_ready};
      S_TOT:   return {25'd0, pend_total};
      default: return x17;
    endcase
  endfunction

  // Monitor: drains every queued expectation when stimulus signals a strobe.
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        item_t it;
        logic [31:0] act;
        it  = q.pop_front();
        act = observe(it.sel);
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", it.nm, act, it.exp, $time);
        end
      end
    end
  end

  task automatic expect_v(input string nm, input sel_e s, input logic [31:0] v);
    item_t it;
    it.nm  = nm;
    it.sel = s;
    it.exp = v;
    q.push_back(it);
  endtask

  task automatic settle();
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_rd = '0; wr_en = 1'b0; wr_rd = '0; wr_data = '0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rs1 = 5'd2; rs2 = 5'd5;
    idle();
    #11;
    expect_v("rst_sp",      S_RS1D, 32'h2ffc);
    expect_v("rst_tot",     S_TOT,  0);
    expect_v("rst_busy1",   S_RS1B, 0);
    expect_v("rst_busy2",   S_RS2B, 0);
    settle();
    reset = 1'b1;
    next_cycle();
    expect_v("rel_sp",      S_RS1D, 32'h2ffc);
    expect_v("rel_x5",      S_RS2D, 0);
    expect_v("rel_tot",     S_TOT,  0);
    expect_v("rel_busy1",   S_RS1B, 0);
    expect_v("rel_busy2",   S_RS2B, 0);
    settle();

    // Issue to x5, then read it busy, then bypass its writeback.
    iss_en = 1'b1; iss_rd = 5'd5;
    expect_v("iss5_rdy", S_RDY, 1);
    settle();
    next_cycle();
    idle(); rs1 = 5'd5; rs2 = 5'd5;
    expect_v("x5_busy",  S_RS1B, 1);
    expect_v("x5_tot1",  S_TOT,  1);
    expect_v("x5_old",   S_RS1D, 0);
    settle();
    wr_en = 1'b1; wr_rd = 5'd5; wr_data = 32'hABCD;
    expect_v("x5_byp1",  S_RS1D, 32'hABCD);
    expect_v("x5_byp2",  S_RS2D, 32'hABCD);
    expect_v("x5_nbusy", S_RS1B, 0);
    expect_v("x5_tot_h", S_TOT,  1);
    settle();
    next_cycle();
    idle();
    expect_v("x5_store", S_RS1D, 32'hABCD);
    expect_v("x5_tot0",  S_TOT,  0);
    expect_v("x5_idle",  S_RS2B, 0);
    settle();

    // Saturate x7 (PMAX=3), drop fourth issue, then accept it against a writeback.
    rs1 = 5'd7; rs2 = 5'd7;
    iss_en = 1'b1; iss_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      expect_v("x7_rdy_fill", S_RDY, 1);
      settle();
      next_cycle();
    end
    expect_v("x7_full",  S_RDY,  0);
    expect_v("x7_tot3",  S_TOT,  3);
    expect_v("x7_busy",  S_RS2B, 1);
    settle();
    next_cycle();
    expect_v("x7_drop",  S_TOT,  3);
    settle();
    wr_en = 1'b1; wr_rd = 5'd7; wr_data = 32'h77;
    expect_v("x7_wb_rdy", S_RDY,  1);
    expect_v("x7_wb_bsy", S_RS1B, 1);
    settle();
    next_cycle();
    idle();
    expect_v("x7_keep3", S_TOT,  3);
    expect_v("x7_data",  S_RS1D, 32'h77);
    settle();
    wr_en = 1'b1; wr_rd = 5'd7; wr_data = 32'h78;
    for (int i = 0; i < 3; i++) next_cycle();
    idle();
    expect_v("x7_drain", S_TOT,  0);
    expect_v("x7_last",  S_RS1D, 32'h78);
    expect_v("x7_free",  S_RS1B, 0);
    settle();

    // Flush with same-cycle issue and writeback to x9.
    rs1 = 5'd9; rs2 = 5'd9;
    iss_en = 1'b1; iss_rd = 5'd9;
    next_cycle();
    next_cycle();
    expect_v("x9_tot2",  S_TOT, 2);
    settle();
    flush = 1'b1; wr_en = 1'b1; wr_rd = 5'd9; wr_data = 32'd5;
    expect_v("fl_rdy",   S_RDY, 1);
    settle();
    next_cycle();
    idle();
    expect_v("fl_tot",   S_TOT,  0);
    expect_v("fl_data",  S_RS1D, 32'd5);
    expect_v("fl_busy",  S_RS1B, 0);
    settle();

    // Writeback to an idle register must not underflow its counter.
    wr_en = 1'b1; wr_rd = 5'd17; wr_data = 32'h5d;
    next_cycle();
    idle();
    expect_v("uf_tot",   S_TOT, 0);
    expect_v("x17_val",  S_X17, 32'h5d);
    settle();

    // x0: writes ignored, issue always ready and uncounted.
    rs1 = 5'd0; rs2 = 5'd0;
    wr_en = 1'b1; wr_rd = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_rd = 5'd0;
    expect_v("x0_byp",   S_RS1D, 0);
    expect_v("x0_rdy",   S_RDY,  1);
    expect_v("x0_busy",  S_RS2B, 0);
    settle();
    next_cycle();
    idle();
    expect_v("x0_read",  S_RS2D, 0);
    expect_v("x0_tot",   S_TOT,  0);
    settle();

    // Build pend_total=4, then assert reset between edges.
    rs1 = 5'd2;
    iss_en = 1'b1; iss_rd = 5'd3;
    next_cycle();
    next_cycle();
    iss_rd = 5'd4;
    next_cycle();
    next_cycle();
    idle();
    expect_v("pre_tot4", S_TOT, 4);
    settle();
    reset = 1'b0;
    expect_v("mid_tot",  S_TOT,  0);
    expect_v("mid_x17",  S_X17,  0);
    expect_v("mid_sp",   S_RS1D, 32'h2ffc);
    settle();
    reset = 1'b1;
    next_cycle();

    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d unchecked expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter PW, default 2: per-register pending-writer counter width; PMAX = 2^PW-1.
REQ-004 Parameter SP_IDX, default 2: index of the stack-pointer register.
REQ-005 Parameter SP_INIT, default 32'h2ffc: stack-pointer value after reset.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 rs1, rs2  input  AW each  source register indices.
REQ-009 rs1_dout, rs2_dout  output  XLEN each  source read data, combinational.
REQ-010 rs1_busy, rs2_busy  output  1 each  source has an outstanding writer after this cycle's writeback.
REQ-011 iss_en  input  1  issue request: the instruction writing iss_rd enters the pipeline.
REQ-012 iss_rd  input  AW  destination of the issuing instruction.
REQ-013 iss_ready  output  1  issue accepted this cycle when iss_en is high.
REQ-014 wr_en  input  1  writeback valid.
REQ-015 wr_rd  input  AW  writeback destination.
REQ-016 wr_data  input  XLEN  writeback data.
REQ-017 flush  input  1  synchronous clear of all pending counters (pipeline flush).
REQ-018 pend_total  output  AW+PW  sum of all pending counters.
REQ-019 x17  output  XLEN  current content of register 17 (ecall detection).

Function
REQ-020 Register 0 SHALL read as 0, SHALL ignore writes, and its counter SHALL stay 0; iss_rd=0 is always ready and has no effect.
REQ-021 A read of rsN SHALL return wr_data when wr_en=1 and wr_rd=rsN!=0 in the same cycle (bypass), otherwise the stored value.
REQ-022 Writeback SHALL update the stored register at the rising edge when wr_en=1 and wr_rd!=0.
REQ-023 Each register r SHALL hold counter pend[r]: +1 on accepted issue to r, -1 on writeback to r, unchanged when both occur in the same cycle.
REQ-024 Writeback to a register with pend=0 SHALL write data and leave pend at 0 (no underflow).
REQ-025 rsN_busy SHALL equal (pend[rsN] - (wr_en and wr_rd=rsN ? 1 : 0)) != 0, rsN!=0.
REQ-026 iss_ready SHALL be low only when flush=0, iss_rd!=0, pend[iss_rd]=PMAX and no same-cycle writeback to iss_rd.
REQ-027 Issue with iss_en=1 and iss_ready=0 SHALL be dropped; the producer holds iss_en/iss_rd until accepted.
REQ-028 flush=1 SHALL zero every counter at the edge, drop any same-cycle issue, and still perform any same-cycle data write.
REQ-029 pend_total SHALL reflect registered counter state (one-cycle latency after issue/writeback).
REQ-030 Read outputs, busy flags and iss_ready SHALL be zero-latency combinational functions of inputs and state.

Reset
REQ-031 While reset=0: all registers 0 except register SP_IDX = SP_INIT; all counters 0; pend_total=0; rs*_busy=0.
REQ-032 Reset assertion mid-operation SHALL discard pending issues/writebacks without waiting for a clock edge.
REQ-033 First state update after reset release SHALL occur on the first rising clk edge with reset=1.

Structure
REQ-034 A shared package regfile_pkg SHALL hold defaults XLEN, NREG, PW, SP_IDX, SP_INIT and the x17 index constant.
REQ-035 Per-register counting SHALL be a sub-module pend_counter (inc, dec, clr, saturation flag), one instance per register 1..NREG-1.
REQ-036 Storage SHALL be a flop array with per-register write enable; no memory macros.

Verification
REQ-037 Reset release -> rs1=2 reads 32'h2ffc, rs2=5 reads 0, pend_total=0, both busy 0.
REQ-038 iss_en, iss_rd=5 for 1 cycle; next cycle rs1=5 -> rs1_busy=1, pend_total=1; wr_en,wr_rd=5,wr_data=32'hABCD that cycle -> rs1_dout=32'hABCD, rs1_busy=0 same cycle.
REQ-039 Issue to x7 three times (PW=2) -> fourth issue sees iss_ready=0 and is dropped; same cycle with wr_rd=7 -> iss_ready=1, pend[7] stays 3.
REQ-040 Issue to x9 twice, then flush=1 with iss_en to x9 and wr_en to x9 data 5 -> next cycle pend_total=0, x9 reads 5, rs1_busy=0.
REQ-041 wr_en, wr_rd=0, wr_data=32'hFFFF_FFFF; iss_rd=0 -> x0 reads 0, iss_ready=1, pend_total unchanged.
REQ-042 reset=0 asserted mid-cycle with pend_total=4 -> pend_total=0 and register 17 reads 0 before next clk edge.
